// File: rtl/seq_controller.sv
// Multi-cycle stage sequencer for the Y86 sequential core: owns the PC, steps the
// stages with one-hot strobes, waits on data memory and converts faults into a status code.
module seq_controller #(
  parameter int                     PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter int                     MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [3:0]          icode,
  input  logic                invalid_instr,
  input  logic                imem_error,
  input  logic [PC_WIDTH-1:0] valC,
  input  logic [PC_WIDTH-1:0] valP,
  input  logic                cnd,
  input  logic [PC_WIDTH-1:0] valM,
  input  logic                dmem_ack,
  input  logic                dmem_error,
  output logic [PC_WIDTH-1:0] PC,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                execute_en,
  output logic                wb_en,
  output logic                pc_en,
  output logic                mem_req,
  output logic [2:0]          stat,
  output logic                busy,
  output logic                done,
  output logic [31:0]         instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_STOP
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [2:0]          stat_q, stat_d;
  logic [WAIT_W-1:0]   wait_q;
  logic [3:0]          icode_q;
  logic [PC_WIDTH-1:0] valc_q, valp_q, valm_q;
  logic                cnd_q;
  logic [PC_WIDTH-1:0] next_pc;
  logic                mem_op;

  // Stages that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
  assign mem_op = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (avoids latch inference).
    state_d = state_q;
    stat_d  = stat_q;
    unique case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          state_d = S_STOP;
          stat_d  = STAT_ADR;
        end else if (invalid_instr) begin
          state_d = S_STOP;
          stat_d  = STAT_INS;
        end else if (icode == 4'h0) begin
          state_d = S_STOP;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = mem_op ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (dmem_ack) begin
          state_d = dmem_error ? S_STOP : S_WRITEBACK;
          if (dmem_error) stat_d = STAT_ADR;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_STOP;
          stat_d  = STAT_ADR;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD:     state_d = run ? S_FETCH : S_IDLE;
      S_STOP:      state_d = S_STOP;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    next_pc = valp_q;
    if (icode_q == 4'h8 || (icode_q == 4'h7 && cnd_q)) next_pc = valc_q;
    else if (icode_q == 4'h9)                           next_pc = valm_q;
  end

  // NOTE: operand latches are reset too, so next_pc is never X-driven after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC          <= RESET_PC;
      stat_q      <= STAT_AOK;
      instr_count <= '0;
      wait_q      <= '0;
      icode_q     <= '0;
      valc_q      <= '0;
      valp_q      <= '0;
      valm_q      <= '0;
      cnd_q       <= 1'b0;
    end else begin
      stat_q <= stat_d;
      wait_q <= (state_q == S_MEMORY) ? wait_q + WAIT_W'(1) : '0;
      unique case (state_q)
        S_FETCH: begin
          icode_q <= icode;
          valc_q  <= valC;
          valp_q  <= valP;
        end
        S_EXECUTE: cnd_q <= cnd;
        S_MEMORY:  if (dmem_ack && !dmem_error) valm_q <= valM;
        S_PCUPD: begin
          PC          <= next_pc;
          instr_count <= instr_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign fetch_en   = (state_q == S_FETCH);
  assign decode_en  = (state_q == S_DECODE);
  assign execute_en = (state_q == S_EXECUTE);
  assign mem_req    = (state_q == S_MEMORY);
  assign wb_en      = (state_q == S_WRITEBACK);
  assign pc_en      = (state_q == S_PCUPD);
  assign busy       = (state_q != S_IDLE) && (state_q != S_STOP);
  assign done       = (state_q == S_STOP);
  assign stat       = stat_q;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: the bench plays fetch/execute/memory,
// queues the expected outcome of each instruction and compares when it retires or stops.
module tb_seq_controller;

  localparam int          PC_WIDTH    = 64;
  localparam logic [63:0] RESET_PC    = 64'h13;
  localparam int          MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [3:0]  icode;
  logic        invalid_instr, imem_error, cnd, dmem_ack, dmem_error;
  logic [63:0] valC, valP, valM;
  logic [63:0] PC;
  logic        fetch_en, decode_en, execute_en, wb_en, pc_en, mem_req, busy, done;
  logic [2:0]  stat;
  logic [31:0] instr_count;

  seq_controller #(
    .PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .icode(icode), .invalid_instr(invalid_instr),
    .imem_error(imem_error), .valC(valC), .valP(valP), .cnd(cnd), .valM(valM),
    .dmem_ack(dmem_ack), .dmem_error(dmem_error), .PC(PC), .fetch_en(fetch_en),
    .decode_en(decode_en), .execute_en(execute_en), .wb_en(wb_en), .pc_en(pc_en),
    .mem_req(mem_req), .stat(stat), .busy(busy), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          mem;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] model_pc;
  logic [31:0] model_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; icode = 4'h1; invalid_instr = 1'b0; imem_error = 1'b0;
    cnd = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0; valC = '0; valP = '0; valM = '0;
    tick();
    tick();
    rst = 1'b0;
    model_pc  = RESET_PC;
    model_cnt = '0;
  endtask

  // Plays one instruction from its FETCH cycle to retirement or STOP.
  // ack_k = MEMORY cycle carrying dmem_ack (0 = never); stray drives an erroring ack outside MEMORY.
  task automatic exec_instr(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                            input logic [63:0] vm, input logic c, input int ack_k,
                            input logic derr, input logic inv, input logic imerr,
                            input logic stray, input string name);
    exp_t e, x;
    int   cyc, memc, n;
    bit   fin, is_mem;
    e.mem = 0; e.done = 1'b0; e.stat = 3'd1; e.pc = model_pc; e.cnt = model_cnt;
    is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    if (imerr)              begin e.stat = 3'd3; e.done = 1'b1; e.lat = 2; end
    else if (inv)           begin e.stat = 3'd4; e.done = 1'b1; e.lat = 2; end
    else if (ic == 4'h0)    begin e.stat = 3'd2; e.done = 1'b1; e.lat = 2; end
    else if (is_mem && (ack_k < 1 || ack_k > MEM_TIMEOUT)) begin
      e.stat = 3'd3; e.done = 1'b1; e.mem = MEM_TIMEOUT; e.lat = 4 + MEM_TIMEOUT;
    end else if (is_mem && derr) begin
      e.stat = 3'd3; e.done = 1'b1; e.mem = ack_k; e.lat = 4 + ack_k;
    end else begin
      e.mem = is_mem ? ack_k : 0;
      e.lat = 5 + e.mem;
      if (ic == 4'h8 || (ic == 4'h7 && c)) e.pc = vc;
      else if (ic == 4'h9)                 e.pc = vm;
      else                                 e.pc = vp;
      e.cnt = model_cnt + 32'd1;
      model_pc  = e.pc;
      model_cnt = e.cnt;
    end
    sb.push_back(e);

    n = 0;
    while (!fetch_en && n < 30) begin tick(); n++; end
    icode = ic; valC = vc; valP = vp; valM = vm; cnd = c;
    invalid_instr = inv; imem_error = imerr; dmem_ack = stray; dmem_error = stray;
    cyc = 1; memc = 0; fin = 0;
    if (fetch_en) begin
      while (!fin && cyc < 40) begin
        tick();
        cyc++;
        if (mem_req) begin
          memc++;
          dmem_ack = (memc == ack_k); dmem_error = derr;
        end else begin
          dmem_ack = stray; dmem_error = stray;
        end
        if (pc_en || done) fin = 1;
      end
    end
    if (fin && pc_en) tick();
    dmem_ack = 1'b0; dmem_error = 1'b0; invalid_instr = 1'b0; imem_error = 1'b0;

    x = sb.pop_front();
    n_checks++;
    if (!fin) $display("FAIL %s: timeout waiting for pc_en/done (got none, need one)", name);
    else begin
      n_pass++;
      n_checks++;
      if (cyc !== x.lat) $display("FAIL %s latency: got %0d need %0d", name, cyc, x.lat);
      else n_pass++;
      n_checks++;
      if (memc !== x.mem) $display("FAIL %s mem_req cycles: got %0d need %0d", name, memc, x.mem);
      else n_pass++;
      n_checks++;
      if (PC !== x.pc) $display("FAIL %s PC: got %h need %h", name, PC, x.pc);
      else n_pass++;
      n_checks++;
      if (stat !== x.stat) $display("FAIL %s stat: got %0d need %0d", name, stat, x.stat);
      else n_pass++;
      n_checks++;
      if (done !== x.done) $display("FAIL %s done: got %b need %b", name, done, x.done);
      else n_pass++;
      n_checks++;
      if (instr_count !== x.cnt) $display("FAIL %s count: got %0d need %0d", name, instr_count, x.cnt);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en, busy, done} !== 8'h00)
      $display("FAIL reset strobes: got %b need 00000000",
               {fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en, busy, done});
    else n_pass++;
    n_checks++;
    if (PC !== RESET_PC || stat !== 3'd1 || instr_count !== 32'd0)
      $display("FAIL reset regs: got PC=%h stat=%0d cnt=%0d need PC=%h stat=1 cnt=0",
               PC, stat, instr_count, RESET_PC);
    else n_pass++;
    run = 1'b1;
    exec_instr(4'h1, 64'h0, 64'h14, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "first_nop");
  endtask

  task automatic test_jxx();
    exec_instr(4'h7, 64'h100, 64'h1C, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "jxx_not_taken");
    exec_instr(4'h7, 64'h100, 64'h1C, 64'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, "jxx_taken");
  endtask

  task automatic test_memory();
    exec_instr(4'h8, 64'h1000_0001, 64'h109, 64'h0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, "call");
    exec_instr(4'h9, 64'h0, 64'h1000_0002, 64'h2A, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, "ret");
    exec_instr(4'h5, 64'h0, 64'h34, 64'h0, 1'b0, MEM_TIMEOUT, 1'b0, 1'b0, 1'b0, 1'b0, "mrmov_late_ack");
    exec_instr(4'h6, 64'h77, 64'h36, 64'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "opq");
  endtask

  task automatic test_run_drop();
    int fetches = 0;
    run = 1'b0;
    exec_instr(4'h2, 64'h0, 64'h40, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "run_drop");
    for (int i = 0; i < 5; i++) begin
      if (fetch_en || busy) fetches++;
      tick();
    end
    n_checks++;
    if (fetches !== 0) $display("FAIL run_drop idle: got %0d busy cycles need 0", fetches);
    else n_pass++;
    run = 1'b1;
    exec_instr(4'h1, 64'h0, 64'h41, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "run_resume");
  endtask

  task automatic test_halt();
    int strobes = 0;
    exec_instr(4'h0, 64'h0, 64'h99, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "halt");
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fetch_en || decode_en || execute_en || mem_req || wb_en || pc_en) strobes++;
    end
    n_checks++;
    if (strobes !== 0 || done !== 1'b1 || PC !== model_pc || stat !== 3'd2)
      $display("FAIL halt hold: got strobes=%0d done=%b PC=%h stat=%0d need 0/1/%h/2",
               strobes, done, PC, model_pc, stat);
    else n_pass++;
  endtask

  task automatic test_faults();
    do_reset(); run = 1'b1;
    exec_instr(4'h3, 64'h0, 64'h20, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "invalid");
    do_reset(); run = 1'b1;
    exec_instr(4'h3, 64'h0, 64'h20, 64'h0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, "imem_over_invalid");
    do_reset(); run = 1'b1;
    exec_instr(4'h1, 64'h0, 64'h14, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "pre_timeout");
    exec_instr(4'h5, 64'h0, 64'h1E, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "mem_timeout");
    do_reset(); run = 1'b1;
    exec_instr(4'hA, 64'h0, 64'h16, 64'h0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, "dmem_error");
  endtask

  task automatic test_rst_mid();
    int n = 0;
    do_reset(); run = 1'b1;
    for (int i = 0; i < 7; i++)
      exec_instr(4'h1, 64'h0, 64'h20 + 64'(i), 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "nop_fill");
    icode = 4'h4; dmem_ack = 1'b0;
    while (!mem_req && n < 10) begin tick(); n++; end
    n_checks++;
    if (!mem_req || instr_count !== 32'd7)
      $display("FAIL rst_mid setup: got mem_req=%b cnt=%0d need 1/7", mem_req, instr_count);
    else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || PC !== RESET_PC || instr_count !== 32'd0 || stat !== 3'd1)
      $display("FAIL rst_mid: got mem_req=%b busy=%b PC=%h cnt=%0d stat=%0d need 0/0/%h/0/1",
               mem_req, busy, PC, instr_count, stat, RESET_PC);
    else n_pass++;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_jxx();
    test_memory();
    test_run_drop();
    test_halt();
    test_faults();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_controller.md
# seq_controller

Multi-cycle stage sequencer for the Y86 sequential core. It owns the program counter and steps the fetch, decode, execute, memory and writeback blocks through one instruction at a time using one-hot stage strobes. It handles variable-latency data-memory handshakes, selects the next PC, and converts halt, invalid-instruction and memory faults into a Y86 status code that stops the machine.

## Interface
- PC_WIDTH, 64, width of the PC and of valC/valP/valM
- RESET_PC, 0, PC value loaded on reset
- MEM_TIMEOUT, 15, maximum MEMORY cycles to wait for dmem_ack before an ADR fault (≥1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; allows leaving IDLE and continuing past PCUPD
- icode  in  4  instruction code from fetch
- invalid_instr  in  1  fetch flags an illegal icode/ifun
- imem_error  in  1  fetch address out of instruction memory
- valC  in  PC_WIDTH  constant/destination from fetch
- valP  in  PC_WIDTH  fall-through PC from fetch
- cnd  in  1  condition result from execute
- valM  in  PC_WIDTH  data read from memory (return address for ret)
- dmem_ack  in  1  data memory completed the current access
- dmem_error  in  1  qualifies dmem_ack; access faulted
- PC  out  PC_WIDTH  current instruction address
- fetch_en, decode_en, execute_en, wb_en, pc_en  out  1 each  stage strobes
- mem_req  out  1  data-memory request, held until ack
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  out  1  state is neither IDLE nor STOP
- done  out  1  machine stopped; held until rst
- instr_count  out  32  retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP. Strobes are a Moore decode of the state: fetch_en=FETCH, decode_en=DECODE, execute_en=EXECUTE, mem_req=MEMORY, wb_en=WRITEBACK, pc_en=PCUPD. At most one strobe is high.
- IDLE -> FETCH when run=1; otherwise stay in IDLE.
- FETCH (1 cycle): latch icode, valC and valP. Priority at the end of the cycle: imem_error -> STOP with stat=3; else invalid_instr -> STOP with stat=4; else icode=0 -> STOP with stat=2; else DECODE.
- DECODE -> EXECUTE, 1 cycle each.
- EXECUTE: latch cnd. If the latched icode is in {4,5,8,9,A,B}, go to MEMORY; otherwise go to WRITEBACK.
- MEMORY: mem_req stays high. dmem_ack is sampled every cycle.
  - Ack with dmem_error=1 -> STOP with stat=3.
  - Ack with dmem_error=0 -> latch valM and go to WRITEBACK.
  - A wait counter counts MEMORY cycles. If no ack has arrived by the end of cycle MEM_TIMEOUT -> STOP with stat=3.
  - dmem_ack is ignored in every other state.
- WRITEBACK (1 cycle) -> PCUPD.
- PCUPD: PC <= next PC, and instr_count increments (wraps 0xFFFFFFFF -> 0). Then go to FETCH if run=1, else IDLE.
- Next PC selection:
  - icode 8 (call): latched valC
  - icode 7 (jXX) with cnd=1: latched valC
  - icode 9 (ret): latched valM
  - all other cases: latched valP
- STOP: no strobes, PC frozen, stat and done held. Only rst leaves STOP.
- PC is not advanced on halt or on any fault, so it still addresses the offending instruction.

## Timing
- Reset values: state=IDLE, PC=RESET_PC, all strobes 0, stat=1, busy=0, done=0, instr_count=0, wait counter 0.
- rst has priority over every event, including one arriving mid-instruction. A strobe (e.g. mem_req) that was high in the cycle rst is sampled is low in the next cycle. No PC or count update occurs on that edge.
- Latency from FETCH entry to the pc_en cycle, inclusive:
  - non-memory instruction: 5 cycles
  - memory instruction with ack in MEMORY cycle k: 5+k cycles (k=1 means ack in the first MEMORY cycle)
- With run held high, the next fetch_en follows pc_en in the very next cycle.
- run is only sampled in IDLE and PCUPD. Dropping run mid-instruction completes the current instruction, then parks in IDLE.
- PC changes on the clock edge that ends PCUPD. The PC output is visible to fetch from the following FETCH cycle.

## Test plan
- Reset with RESET_PC=0x13, run=1, icode=1, valP=0x14: fetch_en in cycle 1, pc_en in cycle 5, then PC=0x14, instr_count=1, stat=1.
- Two jXX instructions (icode=7, valC=0x100, valP=0x1C): the one with cnd=0 gives PC=0x1C; the one with cnd=1 gives PC=0x100. No mem_req for either.
- call (icode=8, valC=0x1000_0001) with dmem_ack in the 3rd MEMORY cycle: mem_req high exactly 3 cycles, pc_en in cycle 8, PC=0x1000_0001.
- ret (icode=9) with ack carrying valM=0x2A gives PC=0x2A.
- Fault cases:
  - icode=0: STOP, stat=2, done=1, PC unchanged, no further strobes for 20 cycles.
  - invalid_instr=1: stat=4.
  - mrmovq with no ack for 15 cycles: stat=3.
  - ack with dmem_error=1: stat=3.
- rst pulsed while mem_req=1 with instr_count=7: next cycle mem_req=0, busy=0, PC=RESET_PC, instr_count=0, stat=1.
